// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: on a mispredict it issues a redirect fetch, flushes IF/ID
// and drops the responses that are still in flight for the abandoned fetch stream.
//
//   state | meaning
//   ------+------------------------------------------------------------------
//   IDLE  | no redirect pending; IF fetches sequentially
//   REQ   | redirect request on offer, waiting for fetch_addr_ok
//   DRAIN | redirect accepted; stale responses still being discarded
module branch_redirect_ctrl #(
   parameter int MAX_OUT = 4,
   parameter int CNT_W   = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ex_valid,
   input  logic        ex_br_cancel,
   input  logic [31:0] ex_next_pc,
   input  logic        if_req_fire,
   input  logic        fetch_addr_ok,
   input  logic        fetch_data_ok,
   output logic        fetch_req,
   output logic [31:0] fetch_pc,
   output logic        flush_if_id,
   output logic        discard_data,
   output logic        redirect_busy,
   output logic        fetch_full,
   output logic [31:0] mispredict_cnt,
   output logic        err_underflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] out_cnt;
   logic [CNT_W-1:0] out_next;
   logic [CNT_W-1:0] disc_cnt;
   logic [CNT_W-1:0] disc_dec;
   logic [CNT_W-1:0] disc_next;
   logic             mispredict;
   logic             fetch_inc;
   logic             underflow;

   assign fetch_req     = (state == REQ);
   assign fetch_full    = (out_cnt == CNT_W'(MAX_OUT));
   assign redirect_busy = (state != IDLE) | flush_if_id;
   assign discard_data  = fetch_data_ok & (disc_cnt != '0);

   always_comb begin
      mispredict = ex_valid & ex_br_cancel;
      fetch_inc  = if_req_fire | (fetch_req & fetch_addr_ok);
      underflow  = fetch_data_ok & (out_cnt == '0);

      out_next = out_cnt;
      if (fetch_inc && !fetch_data_ok) begin
         out_next = out_cnt + CNT_W'(1);
      end else if (!fetch_inc && fetch_data_ok && (out_cnt != '0)) begin
         out_next = out_cnt - CNT_W'(1);
      end

      // A new mispredict makes everything in flight after this edge stale,
      // including a request accepted in this very cycle.
      disc_dec  = disc_cnt - CNT_W'(discard_data);
      disc_next = mispredict ? out_next : disc_dec;
   end

   always_comb begin
      state_next = state;
      if (mispredict) begin
         state_next = REQ;
      end else begin
         case (state)
            IDLE:    state_next = IDLE;
            REQ:     if (fetch_addr_ok) state_next = (disc_dec == '0) ? IDLE : DRAIN;
            DRAIN:   if (disc_dec == '0) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state          <= IDLE;
         out_cnt        <= '0;
         disc_cnt       <= '0;
         fetch_pc       <= '0;
         flush_if_id    <= 1'b0;
         mispredict_cnt <= '0;
         err_underflow  <= 1'b0;
      end else begin
         state       <= state_next;
         out_cnt     <= out_next;
         disc_cnt    <= disc_next;
         flush_if_id <= mispredict;
         if (mispredict) begin
            fetch_pc       <= ex_next_pc;
            mispredict_cnt <= mispredict_cnt + 32'd1;
         end
         if (underflow) begin
            err_underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: hand-computed expectations checked with
// immediate assertions; inputs change 1ns after the rising edge.
module tb_branch_redirect_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ex_valid;
   logic        ex_br_cancel;
   logic [31:0] ex_next_pc;
   logic        if_req_fire;
   logic        fetch_addr_ok;
   logic        fetch_data_ok;
   logic        fetch_req;
   logic [31:0] fetch_pc;
   logic        flush_if_id;
   logic        discard_data;
   logic        redirect_busy;
   logic        fetch_full;
   logic [31:0] mispredict_cnt;
   logic        err_underflow;

   int checks   = 0;
   int failures = 0;

   branch_redirect_ctrl #(.MAX_OUT(4), .CNT_W(3)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .ex_valid       (ex_valid),
      .ex_br_cancel   (ex_br_cancel),
      .ex_next_pc     (ex_next_pc),
      .if_req_fire    (if_req_fire),
      .fetch_addr_ok  (fetch_addr_ok),
      .fetch_data_ok  (fetch_data_ok),
      .fetch_req      (fetch_req),
      .fetch_pc       (fetch_pc),
      .flush_if_id    (flush_if_id),
      .discard_data   (discard_data),
      .redirect_busy  (redirect_busy),
      .fetch_full     (fetch_full),
      .mispredict_cnt (mispredict_cnt),
      .err_underflow  (err_underflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic mispredict(input logic [31:0] pc);
      ex_valid     = 1'b1;
      ex_br_cancel = 1'b1;
      ex_next_pc   = pc;
   endtask

   task automatic clear_ex();
      ex_valid     = 1'b0;
      ex_br_cancel = 1'b0;
      ex_next_pc   = 32'h0;
   endtask

   initial begin
      resetn        = 1'b0;
      clear_ex();
      if_req_fire   = 1'b0;
      fetch_addr_ok = 1'b0;
      fetch_data_ok = 1'b0;
      #12;
      chk("rst_fetch_req", 32'(fetch_req), 32'd0);
      chk("rst_fetch_pc", fetch_pc, 32'h0);
      chk("rst_flush", 32'(flush_if_id), 32'd0);
      chk("rst_busy", 32'(redirect_busy), 32'd0);
      chk("rst_full", 32'(fetch_full), 32'd0);
      chk("rst_mcnt", mispredict_cnt, 32'd0);
      chk("rst_err", 32'(err_underflow), 32'd0);
      resetn = 1'b1;
      tick();

      // Redirect with nothing outstanding
      mispredict(32'h1C000100);
      tick();
      clear_ex();
      chk("s1_flush", 32'(flush_if_id), 32'd1);
      chk("s1_fetch_req", 32'(fetch_req), 32'd1);
      chk("s1_fetch_pc", fetch_pc, 32'h1C000100);
      chk("s1_busy", 32'(redirect_busy), 32'd1);
      chk("s1_mcnt", mispredict_cnt, 32'd1);
      fetch_addr_ok = 1'b1;
      tick();
      fetch_addr_ok = 1'b0;
      chk("s1_idle_req", 32'(fetch_req), 32'd0);
      chk("s1_idle_busy", 32'(redirect_busy), 32'd0);
      chk("s1_out", 32'(dut.out_cnt), 32'd1);
      fetch_data_ok = 1'b1;
      #1;
      chk("s1_own_rsp_kept", 32'(discard_data), 32'd0);
      tick();
      fetch_data_ok = 1'b0;
      chk("s1_out_zero", 32'(dut.out_cnt), 32'd0);

      // Two sequential fetches in flight, redirect accepted one cycle late
      if_req_fire = 1'b1;
      tick();
      tick();
      if_req_fire = 1'b0;
      mispredict(32'h1C000200);
      tick();
      clear_ex();
      chk("s2_flush", 32'(flush_if_id), 32'd1);
      chk("s2_disc_load", 32'(dut.disc_cnt), 32'd2);
      tick();
      chk("s2_wait_req", 32'(fetch_req), 32'd1);
      fetch_addr_ok = 1'b1;
      tick();
      fetch_addr_ok = 1'b0;
      chk("s2_drain_req", 32'(fetch_req), 32'd0);
      chk("s2_drain_busy", 32'(redirect_busy), 32'd1);
      fetch_data_ok = 1'b1;
      #1;
      chk("s2_discard1", 32'(discard_data), 32'd1);
      tick();
      chk("s2_discard2", 32'(discard_data), 32'd1);
      tick();
      chk("s2_discard3", 32'(discard_data), 32'd0);
      chk("s2_idle_busy", 32'(redirect_busy), 32'd0);
      tick();
      fetch_data_ok = 1'b0;
      chk("s2_out_zero", 32'(dut.out_cnt), 32'd0);

      // Request held three cycles, then a new mispredict meets addr_ok
      mispredict(32'h1C000200);
      tick();
      clear_ex();
      chk("s3_flush_on", 32'(flush_if_id), 32'd1);
      tick();
      chk("s3_flush_off1", 32'(flush_if_id), 32'd0);
      chk("s3_pc_hold1", fetch_pc, 32'h1C000200);
      chk("s3_busy1", 32'(redirect_busy), 32'd1);
      tick();
      chk("s3_flush_off2", 32'(flush_if_id), 32'd0);
      chk("s3_pc_hold2", fetch_pc, 32'h1C000200);
      chk("s3_req_held", 32'(fetch_req), 32'd1);
      mispredict(32'h1C000300);
      fetch_addr_ok = 1'b1;
      tick();
      clear_ex();
      chk("s4_pc_new", fetch_pc, 32'h1C000300);
      chk("s4_req", 32'(fetch_req), 32'd1);
      chk("s4_flush", 32'(flush_if_id), 32'd1);
      chk("s4_mcnt", mispredict_cnt, 32'd4);
      chk("s4_disc", 32'(dut.disc_cnt), 32'd1);
      tick();
      fetch_addr_ok = 1'b0;
      chk("s4_drain_busy", 32'(redirect_busy), 32'd1);
      chk("s4_drain_req", 32'(fetch_req), 32'd0);
      fetch_data_ok = 1'b1;
      #1;
      chk("s4_discard_old", 32'(discard_data), 32'd1);
      tick();
      chk("s4_keep_own", 32'(discard_data), 32'd0);
      chk("s4_idle", 32'(redirect_busy), 32'd0);
      tick();
      fetch_data_ok = 1'b0;

      // Fill to MAX_OUT, drain, then underflow
      if_req_fire = 1'b1;
      tick();
      tick();
      tick();
      chk("s5_not_full", 32'(fetch_full), 32'd0);
      tick();
      if_req_fire = 1'b0;
      chk("s5_full", 32'(fetch_full), 32'd1);
      fetch_data_ok = 1'b1;
      tick();
      chk("s5_not_full_after", 32'(fetch_full), 32'd0);
      tick();
      tick();
      tick();
      chk("s5_no_err_yet", 32'(err_underflow), 32'd0);
      tick();
      fetch_data_ok = 1'b0;
      chk("s5_err", 32'(err_underflow), 32'd1);
      chk("s5_out_hold0", 32'(dut.out_cnt), 32'd0);
      tick();
      chk("s5_err_sticky", 32'(err_underflow), 32'd1);

      // Reset during DRAIN with two pending discards
      if_req_fire = 1'b1;
      tick();
      tick();
      if_req_fire = 1'b0;
      mispredict(32'h1C000400);
      tick();
      clear_ex();
      fetch_addr_ok = 1'b1;
      tick();
      fetch_addr_ok = 1'b0;
      chk("s6_drain_disc", 32'(dut.disc_cnt), 32'd2);
      chk("s6_drain_busy", 32'(redirect_busy), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      chk("s6_rst_busy", 32'(redirect_busy), 32'd0);
      chk("s6_rst_req", 32'(fetch_req), 32'd0);
      chk("s6_rst_pc", fetch_pc, 32'h0);
      chk("s6_rst_mcnt", mispredict_cnt, 32'd0);
      chk("s6_rst_err", 32'(err_underflow), 32'd0);
      chk("s6_rst_flush", 32'(flush_if_id), 32'd0);
      chk("s6_rst_disc", 32'(dut.disc_cnt), 32'd0);
      #1;
      resetn = 1'b1;
      fetch_data_ok = 1'b1;
      #1;
      chk("s6_no_discard", 32'(discard_data), 32'd0);
      tick();
      fetch_data_ok = 1'b0;
      chk("s6_err_after", 32'(err_underflow), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
